// File: rtl/dcm_reset_sequencer.sv
// DCM reset sequencer: pulses the DCM reset, waits for a stable lock, then releases SYS_RESET.
// Build option DCM_RETRY_LIMIT_EN: stop in FAULT after MAX_RETRIES failed attempts.
module dcm_reset_sequencer #(
    parameter int RST_PULSE_CYCLES = 8,
    parameter int LOCK_TIMEOUT     = 20000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 4
) (
    input  logic       CLK_IN1,
    input  logic       RESET,
    input  logic       CLK_VALID,
    input  logic       FORCE_RESTART,
    output logic       DCM_RESET,
    output logic       SYS_RESET,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT
);

    typedef enum logic [2:0] {
        S_PULSE,
        S_WAIT_LOCK,
        S_STABLE,
`ifdef DCM_RETRY_LIMIT_EN
        S_FAULT,
`endif
        S_RUN
    } state_t;

    localparam logic [15:0] PULSE_LAST  = 16'(RST_PULSE_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
`ifdef DCM_RETRY_LIMIT_EN
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);
`endif

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [3:0]  retry_n;
    logic        sync1;
    logic        valid_s;
    logic        fail;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = RETRY_COUNT;
        fail    = 1'b0;
        unique case (state)
            S_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (valid_s) begin
                    state_n = S_STABLE;
                    cnt_n   = '0;
                end else if (cnt == LOCK_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_STABLE: begin
                if (!valid_s) begin
                    fail = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_RUN: begin
                if (!valid_s) begin
                    fail = 1'b1;
                end
            end
`ifdef DCM_RETRY_LIMIT_EN
            S_FAULT: state_n = S_FAULT;
`endif
            default: state_n = S_PULSE;
        endcase

        // Every failure path funnels here so one cycle counts at most once
        if (fail) begin
            cnt_n   = '0;
            retry_n = (RETRY_COUNT == 4'hF) ? RETRY_COUNT : RETRY_COUNT + 4'd1;
`ifdef DCM_RETRY_LIMIT_EN
            state_n = (retry_n == RETRY_MAX) ? S_FAULT : S_PULSE;
`else
            state_n = S_PULSE;
`endif
        end

        if (FORCE_RESTART) begin
            state_n = S_PULSE;
            cnt_n   = '0;
            retry_n = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            sync1       <= 1'b0;
            valid_s     <= 1'b0;
            state       <= S_PULSE;
            cnt         <= '0;
            RETRY_COUNT <= '0;
            DCM_RESET   <= 1'b1;
            SYS_RESET   <= 1'b1;
            READY       <= 1'b0;
`ifdef DCM_RETRY_LIMIT_EN
            FAULT       <= 1'b0;
`endif
        end else begin
            sync1       <= CLK_VALID;
            valid_s     <= sync1;
            state       <= state_n;
            cnt         <= cnt_n;
            RETRY_COUNT <= retry_n;
            DCM_RESET   <= (state_n == S_PULSE);
            SYS_RESET   <= (state_n != S_RUN);
            READY       <= (state_n == S_RUN);
`ifdef DCM_RETRY_LIMIT_EN
            FAULT       <= (state_n == S_FAULT);
`endif
        end
    end

`ifndef DCM_RETRY_LIMIT_EN
    assign FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Randomized bench for dcm_reset_sequencer against a phase/time model.
// Honours DCM_RETRY_LIMIT_EN the same way the design does.
module tb_dcm_reset_sequencer;

    localparam int RP = 4;
    localparam int LT = 50;
    localparam int SC = 10;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       CLK_VALID = 1'b0;
    logic       FORCE_RESTART = 1'b0;
    logic       DCM_RESET;
    logic       SYS_RESET;
    logic       READY;
    logic       FAULT;
    logic [3:0] RETRY_COUNT;

    int checks = 0;
    int errors = 0;
    int e = 0;

    dcm_reset_sequencer #(
        .RST_PULSE_CYCLES(RP),
        .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES(MR)
    ) dut (
        .CLK_IN1(clk),
        .RESET(RESET),
        .CLK_VALID(CLK_VALID),
        .FORCE_RESTART(FORCE_RESTART),
        .DCM_RESET(DCM_RESET),
        .SYS_RESET(SYS_RESET),
        .READY(READY),
        .FAULT(FAULT),
        .RETRY_COUNT(RETRY_COUNT)
    );

    always #5 clk = ~clk;

    // Behavioural model: which phase we are in and how long we have been there
    typedef enum {M_PULSE, M_WAIT, M_STABLE, M_RUN, M_FAULT} mph_t;
    mph_t mph = M_PULSE;
    int   mtime = 0;
    int   mretry = 0;
    logic hist[$];
`ifdef DCM_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mph = M_PULSE;
        mtime = 0;
        mretry = 0;
        hist.delete();
    endtask

    task automatic model_edge(input logic v, input logic fr);
        logic seen;
        bit   failed;
        hist.push_back(v);
        if (hist.size() > 3) void'(hist.pop_front());
        // Decisions see CLK_VALID from two edges ago
        seen = (hist.size() == 3) ? hist[0] : 1'b0;
        failed = 1'b0;
        if (fr) begin
            mph = M_PULSE;
            mtime = 0;
            mretry = 0;
            return;
        end
        case (mph)
            M_PULSE: begin
                mtime++;
                if (mtime == RP) begin mph = M_WAIT; mtime = 0; end
            end
            M_WAIT: begin
                if (seen) begin
                    mph = M_STABLE;
                    mtime = 0;
                end else begin
                    mtime++;
                    if (mtime == LT) failed = 1'b1;
                end
            end
            M_STABLE: begin
                if (!seen) failed = 1'b1;
                else begin
                    mtime++;
                    if (mtime == SC) begin mph = M_RUN; mtime = 0; end
                end
            end
            M_RUN: if (!seen) failed = 1'b1;
            default: ;
        endcase
        if (failed) begin
            mretry = (mretry < 15) ? mretry + 1 : 15;
            mtime = 0;
            mph = (LIMIT && mretry == MR) ? M_FAULT : M_PULSE;
        end
    endtask

    always @(negedge clk) begin
        chk("dcm_reset", DCM_RESET, mph == M_PULSE);
        chk("sys_reset", SYS_RESET, mph != M_RUN);
        chk("ready", READY, mph == M_RUN);
        chk("fault", FAULT, mph == M_FAULT);
        chk("retry_count", RETRY_COUNT, mretry);
        if (DCM_RESET && !SYS_RESET) chk("sys_low_dcm_high", 1, 0);
    end

    task automatic step(input logic v, input logic fr);
        CLK_VALID = v;
        FORCE_RESTART = fr;
        @(posedge clk);
        if (!RESET) begin
            model_edge(v, fr);
            e++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 RESET = 1'b1;
        model_reset();
        #1;
        chk("async_dcm", DCM_RESET, 1);
        chk("async_sys", SYS_RESET, 1);
        chk("async_ready", READY, 0);
        chk("async_retry", RETRY_COUNT, 0);
        @(posedge clk);
        @(negedge clk);
        RESET = 1'b0;
        e = 0;
    endtask

    initial begin
        int dcm_cnt;
        int ready_at;
        int sys_at;
        int rise_at;
        int dcm_after_fault;
        logic prev_dcm;
        logic lvl;
        int len;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dcm", DCM_RESET, 1);
        chk("rst_sys", SYS_RESET, 1);
        chk("rst_ready", READY, 0);
        chk("rst_fault", FAULT, 0);
        chk("rst_retry", RETRY_COUNT, 0);
        RESET = 1'b0;
        e = 0;

        // Lock arrives 20 cycles into WAIT_LOCK
        dcm_cnt = 1;
        ready_at = -1;
        for (int k = 1; k <= 60; k++) begin
            step(k >= 24, 1'b0);
            if (DCM_RESET) dcm_cnt++;
            if (READY && ready_at < 0) ready_at = e;
        end
        chk("s1_pulse_len", dcm_cnt, 4);
        chk("s1_ready_edge", ready_at, 36);
        chk("s1_retry", RETRY_COUNT, 0);

        // One-cycle lock drop while running
        dcm_cnt = 0;
        sys_at = -1;
        for (int k = 1; k <= 40; k++) begin
            step(k != 5, 1'b0);
            if (DCM_RESET) dcm_cnt++;
            if (SYS_RESET && sys_at < 0) sys_at = k;
        end
        chk("s2_sys_edge", sys_at, 7);
        chk("s2_pulse_len", dcm_cnt, 4);
        chk("s2_retry", RETRY_COUNT, 1);
        chk("s2_relock", READY, 1);

        // Glitch at stable count 7
        do_reset();
        ready_at = -1;
        for (int k = 1; k <= 40; k++) begin
            step(k != 11, 1'b0);
            if (READY && ready_at < 0) ready_at = e;
        end
        chk("s3_ready_edge", ready_at, 28);
        chk("s3_retry", RETRY_COUNT, 1);

        // No lock at all
        do_reset();
        rise_at = -1;
        prev_dcm = 1'b1;
        dcm_after_fault = 0;
        for (int k = 1; k <= (LIMIT ? 300 : 918); k++) begin
            step(1'b0, 1'b0);
            if (DCM_RESET && !prev_dcm && rise_at < 0) rise_at = e;
            if (k > 3 * (RP + LT) && DCM_RESET) dcm_after_fault++;
            prev_dcm = DCM_RESET;
        end
        chk("s4_repulse_edge", rise_at, RP + LT);
        if (LIMIT) begin
            chk("s4_fault", FAULT, 1);
            chk("s4_retry", RETRY_COUNT, 3);
            chk("s4_dcm_quiet", dcm_after_fault, 0);
        end else begin
            chk("s4_fault", FAULT, 0);
            chk("s4_retry_sat", RETRY_COUNT, 15);
        end

        // Forced restart from the stuck state
        step(1'b0, 1'b1);
        chk("s5_force_retry", RETRY_COUNT, 0);
        chk("s5_force_dcm", DCM_RESET, 1);
        chk("s5_force_fault", FAULT, 0);

        // Reset in the middle of WAIT_LOCK
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
        chk("s6_in_wait", DCM_RESET, 0);
        do_reset();

        // Randomized traffic
        lvl = 1'b1;
        for (int seg = 0; seg < 250; seg++) begin
            lvl = ($urandom_range(0, 3) != 0) ? ~lvl : lvl;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(40, 120)
                                              : $urandom_range(1, 20);
            for (int k = 0; k < len; k++)
                step(lvl, $urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
